alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 130 +++++++++++++
 tb/tb_alu_exec.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Integer ALU execute stage: single-cycle logic and arithmetic ops, plus
// multi-cycle shifts done one bit per clock in a serial shifter.
module alu_exec (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  selRd_i,
  output logic        valid_o,
  output logic [31:0] rd_o,
  output logic [4:0]  selRd_o
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [4:0]  sel_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic [31:0] rd_q;

  logic        is_shift;
  logic [4:0]  sh_amt;
  logic        start_shift;
  logic [31:0] imm_result;
  logic [31:0] shift_step;

  assign is_shift    = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);
  assign sh_amt      = rs2_i[4:0];
  assign start_shift = is_shift && (sh_amt != 5'd0);

  // Single-cycle result; a shift by zero simply passes rs1 through.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm_result = '0;
    case (op_i)
      OP_ADD:  imm_result = rs1_i + rs2_i;
      OP_SUB:  imm_result = rs1_i - rs2_i;
      OP_SLT:  imm_result = {31'd0, $signed(rs1_i) < $signed(rs2_i)};
      OP_SLTU: imm_result = {31'd0, rs1_i < rs2_i};
      OP_XOR:  imm_result = rs1_i ^ rs2_i;
      OP_OR:   imm_result = rs1_i | rs2_i;
      OP_AND:  imm_result = rs1_i & rs2_i;
      OP_SLL, OP_SRL, OP_SRA: imm_result = rs1_i;
      default: imm_result = '0;
    endcase
  end

  always_comb begin
    shift_step = acc_q;
    case (op_q)
      OP_SLL:  shift_step = {acc_q[30:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, acc_q[31:1]};
      OP_SRA:  shift_step = {acc_q[31], acc_q[31:1]};
      default: shift_step = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == 5'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q  <= op_i;
            sel_q <= selRd_i;
            if (start_shift) begin
              acc_q <= rs1_i;
              cnt_q <= sh_amt;
            end else begin
              rd_q  <= imm_result;
            end
          end
        end
        SHIFT: begin
          acc_q <= shift_step;
          cnt_q <= cnt_q - 5'd1;
          // Last bit of the shift lands straight in the result register.
          if (cnt_q == 5'd1) rd_q <= shift_step;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign selRd_o = valid_o ? sel_q : 5'd0;
  assign rd_o    = rd_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: driver pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every valid_o.
module tb_alu_exec;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  selRd_i;
  logic        valid_o;
  logic [31:0] rd_o;
  logic [4:0]  selRd_o;

  alu_exec dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .selRd_i (selRd_i),
    .valid_o (valid_o),
    .rd_o    (rd_o),
    .selRd_o (selRd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  sel;
    int          acc;  // cycle number of the accepting edge
    int          due;  // cycle number in which valid_o must be seen
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_rd = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain SV operators, whole shift in one step.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $signed(a) >>> sh;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int extra_cycles(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0001 || op == 4'b0101 || op == 4'b1101) return int'(b[4:0]);
    return 0;
  endfunction

  // One clock of stimulus, applied 1 time unit after the rising edge.
  task automatic drive_cycle(input logic v, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sel, output logic accepted);
    exp_t e;
    @(posedge clk_i);
    #1;
    valid_i = v;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    selRd_i = sel;
    accepted = v && ready_o;
    if (accepted) begin
      e.rd  = model(op, a, b);
      e.sel = sel;
      e.acc = cyc + 1;
      e.due = cyc + 1 + extra_cycles(op, b);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    logic dummy;
    int   guard;
    guard = 0;
    do begin
      drive_cycle(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, dummy);
      guard++;
    end while (sb.size() != 0 && guard < 200);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel);
    logic accepted;
    drain();
    drive_cycle(1'b1, op, a, b, sel, accepted);
    check("send_accept", 32'(accepted), 32'd1);
  endtask

  // Monitor: ready, result, write select, latency and rd hold, every cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      check("ready", 32'(ready_o), 32'((sb.size() == 0) || (cyc < sb[0].acc)));
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rd", rd_o, e.rd);
          check("sel", 32'(selRd_o), 32'(e.sel));
          check("latency", 32'(cyc), 32'(e.due));
          last_rd = e.rd;
        end
      end else begin
        check("sel_idle", 32'(selRd_o), 32'd0);
        check("rd_hold", rd_o, last_rd);
      end
    end
  end

  initial begin
    logic accepted;
    int   n_acc;

    // Reset held while a request is offered: the request must be ignored.
    rst_i   = 1'b1;
    valid_i = 1'b1;
    op_i    = 4'b0000;
    rs1_i   = 32'd1;
    rs2_i   = 32'd2;
    selRd_i = 5'd3;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_rd", rd_o, 32'd0);
    check("reset_sel", 32'(selRd_o), 32'd0);
    mon_en = 1'b1;

    // Directed vectors, including wrap-around, signed/unsigned compare and shifts.
    send(4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd5);
    send(4'b0010, 32'h8000_0000, 32'd1, 5'd6);
    send(4'b0011, 32'h8000_0000, 32'd1, 5'd7);
    send(4'b1101, 32'h8000_0000, 32'd4, 5'd8);
    send(4'b0101, 32'h8000_0000, 32'd4, 5'd9);
    send(4'b0001, 32'd3, 32'h20, 5'd10);
    send(4'b1000, 32'd0, 32'd1, 5'd11);
    send(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd12);
    send(4'b0110, 32'h1234_0000, 32'h0000_5678, 5'd13);
    send(4'b0111, 32'hDEAD_BEEF, 32'hFFFF_0000, 5'd14);
    send(4'b1001, 32'hDEAD_BEEF, 32'h1, 5'd15);
    send(4'b1101, 32'h7FFF_FFFF, 32'd31, 5'd16);
    send(4'b0001, 32'h8000_0001, 32'd1, 5'd0);

    // Long shift aborted by reset in its third SHIFT cycle.
    send(4'b0001, 32'h0000_0001, 32'd31, 5'd17);
    repeat (3) drive_cycle(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, accepted);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    last_rd = 32'd0;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_sel", 32'(selRd_o), 32'd0);
    check("abort_rd", rd_o, 32'd0);
    repeat (40) drive_cycle(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, accepted);

    // valid_i held high with ADDs and operands changing every cycle.
    drain();
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 4'b0000, $urandom, $urandom, 5'($urandom), accepted);
      if (accepted) n_acc++;
    end
    check("throughput", 32'(n_acc), 32'd10);

    // Random opcodes (legal and illegal), random valid_i, mostly short shifts.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) b[4:0] = 5'($urandom_range(0, 5));
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom, b, 5'($urandom), accepted);
    end

    drain();
    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
